// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the asynchronous SRAM bank controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//   Contents: controller state enum, SRAM geometry constants, wait-counter width helper.
package sram_ctrl_pkg;

   localparam int SRAM_AW = 20;   // word address width (1M words)
   localparam int SRAM_DW = 32;   // data width
   localparam int SRAM_BW = 4;    // byte lanes

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WS   = 3'd2,
      WP   = 3'd3,
      WH   = 3'd4,
      DONE = 3'd5
   } state_e;

   // Width of a down-counter that must hold values 0..max(a,b).
   // Never returns 0, so a counter declared with it always has at least one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sram_rdbuf.sv
// sram_rdbuf: one-entry read buffer {valid, addr, data} in front of the SRAM bank.
// Latency: hit is combinational from lookup_addr_i; fill/invalidate take effect at the next clk edge.
// Backpressure: none; fill and invalidate are single-cycle strobes, never stalled.
//   Built only when SRAM_CTRL_RDBUF_EN is defined.
//   Ports: clk, rst (async, active-high); lookup_addr_i -> hit_o, hit_data_o;
//          fill_i/fill_addr_i/fill_data_i load the entry; inv_i/inv_addr_i clear it on an address match.
`ifdef SRAM_CTRL_RDBUF_EN
module sram_rdbuf
   import sram_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [SRAM_AW-1:0] lookup_addr_i,
   output logic               hit_o,
   output logic [SRAM_DW-1:0] hit_data_o,
   input  logic               fill_i,
   input  logic [SRAM_AW-1:0] fill_addr_i,
   input  logic [SRAM_DW-1:0] fill_data_i,
   input  logic               inv_i,
   input  logic [SRAM_AW-1:0] inv_addr_i
);

   logic               valid_q, valid_d;
   logic [SRAM_AW-1:0] addr_q,  addr_d;
   logic [SRAM_DW-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (fill_i) begin
         valid_d = 1'b1;
         addr_d  = fill_addr_i;
         data_d  = fill_data_i;
      end else if (inv_i && (inv_addr_i == addr_q)) begin
         // Any write to the buffered word, even with no byte enables, drops the entry.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign hit_o      = valid_q && (addr_q == lookup_addr_i);
   assign hit_data_o = data_q;

endmodule
`endif

// File: rtl/sram_ctrl.sv
// sram_ctrl: converts a single-outstanding req/ack bus into strobe sequences for one 1M x 32 async SRAM bank.
// Latency: read ack RD_WAIT+2 edges after sampling (buffer hit: 1), write ack WE_PULSE+3 edges after sampling.
// Backpressure: one transaction at a time; req_i is held by the master until ack_o, busy_o=1 outside IDLE.
//   Optional feature: define SRAM_CTRL_RDBUF_EN to add a one-entry read buffer (sram_rdbuf).
//   Ports: clk, rst (async, active-high); core side req_i/we_i/addr_i/be_i/wdata_i -> rdata_o/ack_o/busy_o;
//          SRAM side ram_data (tristate), ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n (all registered).
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int RD_WAIT  = 1,
   parameter int WE_PULSE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [SRAM_AW-1:0] addr_i,
   input  logic [SRAM_BW-1:0] be_i,
   input  logic [SRAM_DW-1:0] wdata_i,
   output logic [SRAM_DW-1:0] rdata_o,
   output logic               ack_o,
   output logic               busy_o,
   inout  wire  [SRAM_DW-1:0] ram_data,
   output logic [SRAM_AW-1:0] ram_addr,
   output logic [SRAM_BW-1:0] ram_be_n,
   output logic               ram_ce_n,
   output logic               ram_oe_n,
   output logic               ram_we_n
);

   localparam int CW = cnt_width(RD_WAIT, WE_PULSE);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q,   cnt_d;
   logic [SRAM_AW-1:0] addr_q,  addr_d;
   logic [SRAM_BW-1:0] be_q,    be_d;
   logic [SRAM_DW-1:0] wdata_q, wdata_d;
   logic [SRAM_DW-1:0] rdata_q, rdata_d;
   logic               ce_n_q,  ce_n_d;
   logic               oe_n_q,  oe_n_d;
   logic               we_n_q,  we_n_d;
   logic [SRAM_BW-1:0] be_n_q,  be_n_d;
   logic               drive_q, drive_d;

   logic               rd_done;    // last RD cycle: ram_data is sampled on this edge
   logic               rd_hit;     // read served from the buffer, bypassing RD
   logic               buf_hit;
   logic [SRAM_DW-1:0] buf_data;

`ifdef SRAM_CTRL_RDBUF_EN
   sram_rdbuf u_rdbuf (
      .clk           (clk),
      .rst           (rst),
      .lookup_addr_i (addr_i),
      .hit_o         (buf_hit),
      .hit_data_o    (buf_data),
      .fill_i        (rd_done),
      .fill_addr_i   (addr_q),
      .fill_data_i   (ram_data),
      .inv_i         ((state_q == IDLE) && req_i && we_i),
      .inv_addr_i    (addr_i)
   );
`else
   assign buf_hit  = 1'b0;
   assign buf_data = '0;
`endif

   // Next state, wait counter and latched request fields.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rd_done = 1'b0;
      rd_hit  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_i) begin
               addr_d  = addr_i;
               be_d    = be_i;
               wdata_d = wdata_i;
               if (we_i) begin
                  state_d = WS;
               end else if (buf_hit) begin
                  state_d = DONE;
                  rd_hit  = 1'b1;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               rd_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WS: state_d = WP;
         WP: begin
            if (cnt_q == '0) begin
               state_d = WH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WH:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The counter reloads on every state entry, so each timed state starts from
      // its full count no matter how it was reached.
      if (state_d != state_q) begin
         case (state_d)
            RD:      cnt_d = CW'(RD_WAIT);
            WP:      cnt_d = CW'(WE_PULSE - 1);
            default: cnt_d = '0;
         endcase
      end
   end

   // Pin values are decoded from the next state and registered, so the pins
   // change on the same edge as the state and never see req_i combinationally.
   always_comb begin
      ce_n_d  = !(state_d inside {RD, WS, WP, WH});
      oe_n_d  = (state_d != RD);
      we_n_d  = (state_d != WP);
      drive_d = (state_d inside {WS, WP, WH});
      case (state_d)
         RD:         be_n_d = '0;       // reads always fetch the full word
         WS, WP, WH: be_n_d = ~be_d;
         default:    be_n_d = '1;
      endcase

      rdata_d = rdata_q;
      if (rd_done) begin
         rdata_d = ram_data;
      end else if (rd_hit) begin
         rdata_d = buf_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         be_n_q  <= '1;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         be_n_q  <= be_n_d;
         drive_q <= drive_d;
      end
   end

   assign ram_data = drive_q ? wdata_q : {SRAM_DW{1'bz}};
   assign ram_addr = addr_q;
   assign ram_be_n = be_n_q;
   assign ram_ce_n = ce_n_q;
   assign ram_oe_n = oe_n_q;
   assign ram_we_n = we_n_q;

   assign rdata_o  = rdata_q;
   assign ack_o    = (state_q == DONE);
   assign busy_o   = (state_q != IDLE);

endmodule
